// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage handshake states and packed
// inter-stage payload bundles.
package cpu_types;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic       insn_vld;
    logic [3:0] alu_op;
    logic       wb_en;
    logic       mem_rd;
    logic       mem_wr;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [4:0]  rd;
  } id_ex_t;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    unique case (s)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: registered in_ready, main + skid
// payload, flush, occupancy and a saturating bubble counter.
module pipe_stage_skid
  import cpu_types::*;
#(
  parameter int DATA_W        = 32,
  parameter int CNT_W         = 16,
  parameter int ZERO_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic              acc;
  logic              rel;

  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid && in_ready_q;
  assign rel       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (ZERO_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc && !rel) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (!acc && rel) begin
            state_d = EMPTY;
          end else if (acc && rel) begin
            main_d = in_data;
          end
        end
        FULL: begin
          if (rel) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // in_ready is precomputed so it never depends on out_ready
    in_ready_d = (state_d != FULL);
    occ_d      = occ_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  sat_counter #(
    .W(CNT_W)
  ) u_bubble (
    .clk  (clk),
    .reset(reset),
    .inc  (out_ready && !out_valid),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed checks for pipe_stage_skid with CNT_W=4.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DW),
    .CNT_W(CW),
    .ZERO_ON_FLUSH(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    step(2);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_iready", 32'(in_ready), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_odata", out_data, 32'd0);
    chk("rst_bubble", 32'(bubble_cnt), 32'd0);

    // single entry, one-cycle latency
    reset = 1'b0;
    out_ready = 1'b1;
    push(32'hA5A5_0001);
    chk("lat_ovalid", 32'(out_valid), 32'd1);
    chk("lat_odata", out_data, 32'hA5A5_0001);
    chk("lat_occ", 32'(occupancy), 32'd1);
    step();
    chk("lat_drain", 32'(out_valid), 32'd0);

    // fill both entries with downstream stalled
    out_ready = 1'b0;
    push(32'h11);
    chk("one_occ", 32'(occupancy), 32'd1);
    push(32'h22);
    chk("full_occ", 32'(occupancy), 32'd2);
    chk("full_iready", 32'(in_ready), 32'd0);
    chk("full_odata", out_data, 32'h11);
    step();
    chk("hold_odata", out_data, 32'h11);
    chk("hold_ovalid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("drain1_odata", out_data, 32'h22);
    chk("drain1_occ", 32'(occupancy), 32'd1);
    chk("drain1_iready", 32'(in_ready), 32'd1);
    step();
    chk("drain2_ovalid", 32'(out_valid), 32'd0);

    // streaming at full rate
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 32'(i + 1);
      step();
      chk("strm_ovalid", 32'(out_valid), 32'd1);
      chk("strm_odata", out_data, 32'(i + 1));
      chk("strm_occ", 32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_end", 32'(out_valid), 32'd0);

    // flush while FULL with a new entry offered
    out_ready = 1'b0;
    push(32'h33);
    push(32'h44);
    chk("fl_full", 32'(occupancy), 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_ovalid", 32'(out_valid), 32'd0);
    chk("fl_odata", out_data, 32'd0);
    chk("fl_iready", 32'(in_ready), 32'd1);
    chk("fl_occ", 32'(occupancy), 32'd0);
    out_ready = 1'b1;
    step();
    chk("fl_no55", 32'(out_valid), 32'd0);

    // flush in ONE discards an entry that would otherwise be accepted
    out_ready = 1'b0;
    push(32'h66);
    chk("fl1_occ", 32'(occupancy), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_ovalid", 32'(out_valid), 32'd0);
    chk("fl1_odata", out_data, 32'd0);
    out_ready = 1'b1;
    step();
    chk("fl1_no77", 32'(out_valid), 32'd0);

    // bubble counter saturation
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step(3);
    chk("bub_3", 32'(bubble_cnt), 32'd3);
    step((1 << CW) + 5 - 3);
    chk("bub_sat", 32'(bubble_cnt), 32'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("bub_flush", 32'(bubble_cnt), 32'd15);
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    chk("bub_rst", 32'(bubble_cnt), 32'd0);

    // reset with flush while FULL
    reset = 1'b0;
    push(32'h88);
    push(32'h99);
    chk("rf_full", 32'(occupancy), 32'd2);
    reset = 1'b1; flush = 1'b1;
    in_valid = 1'b1; in_data = 32'hAA;
    step();
    chk("rf_ovalid", 32'(out_valid), 32'd0);
    chk("rf_odata", out_data, 32'd0);
    chk("rf_occ", 32'(occupancy), 32'd0);
    chk("rf_iready", 32'(in_ready), 32'd1);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    chk("rf_post_ir", 32'(in_ready), 32'd1);
    chk("rf_post_ov", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
